// File: rtl/dsram_responder_pkg.sv
// Shared types and helpers for the data-side SRAM responder.
// Size encodings, response entry layout and request legality check.
package dsram_responder_pkg;

  localparam logic [1:0] SRAM_SIZE_B = 2'd0;
  localparam logic [1:0] SRAM_SIZE_H = 2'd1;
  localparam logic [1:0] SRAM_SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } dsram_resp_t;

  localparam int DSRAM_RESP_BUS_WD = $bits(dsram_resp_t);

  // Misaligned address, illegal size, or a store strobe that is not
  // exactly one aligned lane group of the access size.
  function automatic logic req_bad(
    input logic       wr,
    input logic [1:0] size,
    input logic [1:0] off,
    input logic [3:0] strb
  );
    logic mis;
    logic sok;
    mis = 1'b0;
    sok = 1'b0;
    unique case (1'b1)
      size == SRAM_SIZE_B: begin
        mis = 1'b0;
        sok = $onehot(strb);
      end
      size == SRAM_SIZE_H: begin
        mis = off[0];
        sok = (strb == 4'b0011) || (strb == 4'b1100);
      end
      size == SRAM_SIZE_W: begin
        mis = (off != 2'b00);
        sok = (strb == 4'b1111);
      end
      default: begin
        mis = 1'b1;
        sok = 1'b0;
      end
    endcase
    return mis || (wr && !sok);
  endfunction

endpackage

// File: rtl/dsram_resp_fifo.sv
// In-order response queue with per-entry age counters.
// Head is ready once it has aged RESP_LAT cycles since acceptance.
module dsram_resp_fifo
  import dsram_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LAT   = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  dsram_resp_t   push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          head_ready,
  output dsram_resp_t   head_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = $clog2(LAT + 1);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [AW-1:0] AGE_MAX = AW'(LAT);
  localparam logic [AW-1:0] AGE_ONE = AW'(1);

  dsram_resp_t   ent [DEPTH];
  logic [AW-1:0] age [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + P_ONE;
  endfunction

  // Pointers and occupancy; reset drops every in-flight entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Entry payloads and ages; the accept cycle itself counts as one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wr_ptr == PW'(i)) begin
        ent[i] <= push_data;
        age[i] <= AGE_ONE;
      end else if (age[i] != AGE_MAX) begin
        age[i] <= age[i] + AGE_ONE;
      end
    end
  end

  assign count      = cnt;
  assign head_ready = (cnt != '0) && (age[rd_ptr] == AGE_MAX);
  assign head_data  = ent[rd_ptr];

endmodule

// File: rtl/dsram_responder.sv
// Data-side SRAM-like responder: word RAM, strobe writes, fixed latency
// in-order responses, optional random addr_ok stalls, sticky protocol flag.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          MEM_AW          = 14,
  parameter int          RESP_LAT        = 2,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter string       INIT_FILE       = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        proto_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam bit unused_init_file = (INIT_FILE != "");

  logic [31:0]       mem [2**MEM_AW];
  logic [15:0]       lfsr;
  logic [CW-1:0]     count;
  logic              head_ready;
  dsram_resp_t       head;
  dsram_resp_t       push_data;
  logic              accept;
  logic              stall;
  logic [MEM_AW-1:0] widx;
  logic              unused_bits;

  assign widx  = data_sram_addr[MEM_AW+1:2];
  assign stall = STALL_EN && lfsr[0];

  assign data_sram_data_ok = !reset && head_ready;
  assign data_sram_addr_ok = !reset && !stall &&
    ((count < CW'(MAX_OUTSTANDING)) || data_sram_data_ok);
  assign accept = data_sram_req && data_sram_addr_ok;
  assign data_sram_rdata = data_sram_data_ok ? head.rdata : 32'h0;

  assign push_data.wr    = data_sram_wr;
  assign push_data.rdata = data_sram_wr ? 32'h0 : mem[widx];

  assign unused_bits = ^{data_sram_addr[31:MEM_AW+2], head.wr};

  dsram_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .LAT   (RESP_LAT)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_data  (push_data),
    .pop        (data_sram_data_ok),
    .count      (count),
    .head_ready (head_ready),
    .head_data  (head)
  );

  // Byte-lane store commit on the accepting edge; RAM survives reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b])
          mem[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // Fibonacci LFSR x^16+x^14+x^13+x^11, free running.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Sticky flag for any accepted malformed request.
  always_ff @(posedge clk) begin
    if (reset)
      proto_err <= 1'b0;
    else if (accept && req_bad(data_sram_wr, data_sram_size,
                               data_sram_addr[1:0], data_sram_wstrb))
      proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder: three instances (plain,
// random stalls, single outstanding) each checked against a queue model.
module tb_dsram_responder;

  localparam int          MAW  = 14;
  localparam int          LAT  = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          NL   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [NL];
  logic        req   [NL];
  logic        wr    [NL];
  logic [1:0]  size  [NL];
  logic [3:0]  strb  [NL];
  logic [31:0] addr  [NL];
  logic [31:0] wdata [NL];
  logic        aok   [NL];
  logic        dok   [NL];
  logic [31:0] rdata [NL];
  logic        perr  [NL];
  bit          acc   [NL];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int lane,
                     input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s lane%0d t=%0t got %h want %h",
               name, lane, $time, act, want);
    end
  endtask

  function automatic bit group_ok(input logic [1:0] s, input logic [3:0] st);
    int n;
    if (s == 2'd3) return 1'b0;
    n = 1 << s;
    for (int p = 0; p < 4; p += n)
      if (st == 4'(((1 << n) - 1) << p)) return 1'b1;
    return 1'b0;
  endfunction

  for (genvar k = 0; k < NL; k++) begin : g_lane
    localparam int MO = (k == 2) ? 1 : 2;
    localparam bit SE = (k == 1);

    dsram_responder #(
      .MAX_OUTSTANDING (MO),
      .MEM_AW          (MAW),
      .RESP_LAT        (LAT),
      .STALL_EN        (SE),
      .LFSR_SEED       (SEED),
      .INIT_FILE       ("")
    ) dut (
      .clk               (clk),
      .reset             (rst[k]),
      .data_sram_req     (req[k]),
      .data_sram_wr      (wr[k]),
      .data_sram_size    (size[k]),
      .data_sram_wstrb   (strb[k]),
      .data_sram_addr    (addr[k]),
      .data_sram_wdata   (wdata[k]),
      .data_sram_addr_ok (aok[k]),
      .data_sram_data_ok (dok[k]),
      .data_sram_rdata   (rdata[k]),
      .proto_err         (perr[k])
    );

    logic [31:0] mem [int];
    int          due_q [$];
    logic [31:0] dat_q [$];
    bit          kn_q  [$];
    int          cyc = 0;
    int          last_due = -100;
    logic [15:0] lfsr = SEED;
    bit          perr_m = 1'b0;

    always @(negedge clk) begin : model
      bit          due_now;
      bit          want_dok;
      bit          want_aok;
      bit          bad;
      int          widx;
      int          due;
      logic [31:0] w;
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
        void'(kn_q.pop_front());
      end
      due_now  = due_q.size() > 0 && due_q[0] == cyc;
      want_dok = !rst[k] && due_now;
      want_aok = !rst[k] && (due_q.size() < MO || due_now) && !(SE && lfsr[0]);
      chk("data_ok", k, 32'(dok[k]), 32'(want_dok));
      chk("addr_ok", k, 32'(aok[k]), 32'(want_aok));
      chk("proto_err", k, 32'(perr[k]), 32'(perr_m));
      if (want_dok && dok[k] && kn_q[0])
        chk("rdata", k, rdata[k], dat_q[0]);
      acc[k] = 1'b0;
      if (rst[k]) begin
        due_q.delete();
        dat_q.delete();
        kn_q.delete();
        last_due = -100;
        perr_m = 1'b0;
        lfsr = SEED;
      end else begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (req[k] && aok[k]) begin
          acc[k] = 1'b1;
          widx = int'(addr[k][MAW+1:2]);
          bad = (size[k] == 2'd3) ||
                ((addr[k] & ((32'd1 << size[k]) - 32'd1)) != 0) ||
                (wr[k] && !group_ok(size[k], strb[k]));
          if (bad) perr_m = 1'b1;
          due = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
          last_due = due;
          due_q.push_back(due);
          if (wr[k]) begin
            dat_q.push_back(32'h0);
            kn_q.push_back(1'b1);
            if (mem.exists(widx)) begin
              w = mem[widx];
              for (int b = 0; b < 4; b++)
                if (strb[k][b]) w[8*b +: 8] = wdata[k][8*b +: 8];
              mem[widx] = w;
            end else if (strb[k] == 4'hF) begin
              mem[widx] = wdata[k];
            end
          end else begin
            kn_q.push_back(mem.exists(widx));
            dat_q.push_back(mem.exists(widx) ? mem[widx] : 32'h0);
          end
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input bit w, input logic [1:0] s,
                       input logic [3:0] st, input logic [31:0] a,
                       input logic [31:0] d);
    int n;
    req[k] = 1'b1;
    wr[k] = w;
    size[k] = s;
    strb[k] = st;
    addr[k] = a;
    wdata[k] = d;
    step();
    n = 0;
    while (!acc[k] && n < 200) begin
      step();
      n++;
    end
    chk("accepted", k, 32'(acc[k]), 32'd1);
    req[k] = 1'b0;
  endtask

  task automatic wait_resp(input int k, output logic [31:0] d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dok[k] && n < 50);
    chk("resp_seen", k, 32'(dok[k]), 32'd1);
    d = rdata[k];
  endtask

  task automatic rand_run(input int k, input int cnt);
    logic [31:0] a;
    logic [1:0]  s;
    logic [3:0]  st;
    bit          w;
    int          word;
    int          off;
    for (int i = 0; i < 16; i++)
      issue(k, 1'b1, 2'd2, 4'hF, 32'h1000 + 32'(i * 4), $urandom());
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else begin
        w = 1'($urandom_range(0, 1));
        s = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 63) == 0) s = 2'd3;
        word = $urandom_range(0, 15);
        off = ($urandom_range(0, 3) >> s) << s;
        if ($urandom_range(0, 63) == 0) off = $urandom_range(0, 3);
        a = 32'h1000 + 32'(word * 4 + off);
        a = a | (32'($urandom_range(0, 3)) << (MAW + 2));
        st = 4'(((1 << (1 << s)) - 1) << off);
        if ($urandom_range(0, 63) == 0) st = 4'($urandom_range(0, 15));
        issue(k, w, s, st, a, $urandom());
      end
    end
  endtask

  task automatic directed();
    logic [31:0] d;
    int n;
    issue(0, 1'b1, 2'd2, 4'hF, 32'h1000, 32'h12345678);
    repeat (4) step();
    req[0] = 1'b1;
    wr[0] = 1'b0;
    size[0] = 2'd2;
    strb[0] = 4'h0;
    addr[0] = 32'h1000;
    @(negedge clk);
    chk("t1_addr_ok", 0, 32'(aok[0]), 32'd1);
    chk("t1_dok_t0", 0, 32'(dok[0]), 32'd0);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_dok_t1", 0, 32'(dok[0]), 32'd0);
    step();
    @(negedge clk);
    chk("t1_dok_t2", 0, 32'(dok[0]), 32'd1);
    chk("t1_rdata", 0, rdata[0], 32'h12345678);
    step();
    @(negedge clk);
    chk("t1_dok_t3", 0, 32'(dok[0]), 32'd0);
    step();

    issue(0, 1'b1, 2'd0, 4'b0100, 32'h1002, 32'h00AB0000);
    issue(0, 1'b0, 2'd2, 4'h0, 32'h1000, 32'h0);
    wait_resp(0, d, n);
    chk("t2_store_rdata", 0, d, 32'h0);
    wait_resp(0, d, n);
    chk("t2_load", 0, d, 32'h12AB5678);
    chk("t2_gap", 0, 32'(n), 32'd1);
    step();
    issue(0, 1'b0, 2'd2, 4'h0, 32'h1000 | (32'h1 << (MAW + 2)), 32'h0);
    wait_resp(0, d, n);
    chk("alias", 0, d, 32'h12AB5678);
    step();

    issue(0, 1'b1, 2'd2, 4'hF, 32'h1004, 32'h11111111);
    issue(0, 1'b1, 2'd2, 4'hF, 32'h1008, 32'h22222222);
    repeat (4) step();
    issue(0, 1'b0, 2'd2, 4'h0, 32'h1000, 32'h0);
    issue(0, 1'b0, 2'd2, 4'h0, 32'h1004, 32'h0);
    req[0] = 1'b1;
    addr[0] = 32'h1008;
    @(negedge clk);
    chk("t3_c_addr_ok", 0, 32'(aok[0]), 32'd1);
    chk("t3_dok_a", 0, 32'(dok[0]), 32'd1);
    chk("t3_rd_a", 0, rdata[0], 32'h12AB5678);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t3_dok_b", 0, 32'(dok[0]), 32'd1);
    chk("t3_rd_b", 0, rdata[0], 32'h11111111);
    step();
    @(negedge clk);
    chk("t3_dok_c", 0, 32'(dok[0]), 32'd1);
    chk("t3_rd_c", 0, rdata[0], 32'h22222222);
    step();

    issue(0, 1'b1, 2'd2, 4'hF, 32'h2000, 32'hDEADBEEF);
    issue(0, 1'b0, 2'd2, 4'h0, 32'h2000, 32'h0);
    wait_resp(0, d, n);
    wait_resp(0, d, n);
    chk("t4_raw", 0, d, 32'hDEADBEEF);
    step();

    issue(0, 1'b0, 2'd2, 4'h0, 32'h1000, 32'h0);
    issue(0, 1'b0, 2'd2, 4'h0, 32'h2000, 32'h0);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t5_dok_in_rst", 0, 32'(dok[0]), 32'd0);
    chk("t5_aok_in_rst", 0, 32'(aok[0]), 32'd0);
    step();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("t5_aok_after", 0, 32'(aok[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_dok", 0, 32'(dok[0]), 32'd0);
      step();
      @(negedge clk);
    end
    step();
    issue(0, 1'b0, 2'd2, 4'h0, 32'h2000, 32'h0);
    wait_resp(0, d, n);
    chk("t5_ram_kept", 0, d, 32'hDEADBEEF);
    step();

    chk("t6_perr_clr", 0, 32'(perr[0]), 32'd0);
    issue(0, 1'b0, 2'd2, 4'h0, 32'h1002, 32'h0);
    wait_resp(0, d, n);
    chk("t6_rdata", 0, d, 32'h12AB5678);
    step();
    repeat (5) step();
    @(negedge clk);
    chk("t6_perr_held", 0, 32'(perr[0]), 32'd1);
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("t6_perr_rst", 0, 32'(perr[0]), 32'd0);
    step();
  endtask

  initial begin
    for (int k = 0; k < NL; k++) begin
      rst[k] = 1'b1;
      req[k] = 1'b0;
      wr[k] = 1'b0;
      size[k] = 2'd0;
      strb[k] = 4'h0;
      addr[k] = 32'h0;
      wdata[k] = 32'h0;
    end
    repeat (3) step();
    for (int k = 0; k < NL; k++) rst[k] = 1'b0;
    fork
      begin
        directed();
        rand_run(0, 300);
      end
      rand_run(1, 1000);
      rand_run(2, 400);
    join
    repeat (8) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
